div_issue_queue: RTL and testbench

DIV_ISSUE_QUEUE -- requirements
Module: div_issue_queue

---
 rtl/div_issue_queue_if.sv | 38 +++
 rtl/div_issue_queue.sv | 91 +++++++++
 tb/tb_div_issue_queue.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/div_issue_queue_if.sv
// div_issue_queue_if: dispatch, CDB and issue signals of the divider issue queue (flush port with DIV_IQ_FLUSH_EN)
interface div_issue_queue_if;
  logic        disp_en;
  logic [31:0] disp_op1, disp_op2;
  logic        disp_op1_rdy, disp_op2_rdy;
  logic [5:0]  disp_op1_tag, disp_op2_tag;
  logic [2:0]  disp_funct3;
  logic [5:0]  disp_tag;
  logic        full;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        unit_busy;
  logic        queue_en;
  logic [31:0] op1, op2;
  logic [2:0]  funct3;
  logic [5:0]  tag_out;
  logic [3:0]  count;
`ifdef DIV_IQ_FLUSH_EN
  logic        flush;
`endif
  modport slave (
    input  disp_en, disp_op1, disp_op2, disp_op1_rdy, disp_op2_rdy, disp_op1_tag, disp_op2_tag,
           disp_funct3, disp_tag, cdb_valid, cdb_tag, cdb_data, unit_busy,
    output full, queue_en, op1, op2, funct3, tag_out, count
`ifdef DIV_IQ_FLUSH_EN
    , input flush
`endif
  );
  modport master (
    output disp_en, disp_op1, disp_op2, disp_op1_rdy, disp_op2_rdy, disp_op1_tag, disp_op2_tag,
           disp_funct3, disp_tag, cdb_valid, cdb_tag, cdb_data, unit_busy,
    input  full, queue_en, op1, op2, funct3, tag_out, count
`ifdef DIV_IQ_FLUSH_EN
    , output flush
`endif
  );
endinterface

// File: rtl/div_issue_queue.sv
// div_issue_queue: age-ordered wakeup/select queue feeding the divider; DIV_IQ_FLUSH_EN adds a flush input
module div_issue_queue #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  div_issue_queue_if.slave b
);
  typedef struct packed {
    logic        v;
    logic [31:0] o1;
    logic        r1;
    logic [5:0]  t1;
    logic [31:0] o2;
    logic        r2;
    logic [5:0]  t2;
    logic [2:0]  f3;
    logic [5:0]  tag;
  } entry_t;
  entry_t     q [DEPTH];
  entry_t     w [DEPTH+1];
  entry_t     n [DEPTH];
  entry_t     ne, s;
  logic [3:0] cnt, cnt_n;
  logic       flush, found, issue, accept, full;
  int         sel;
`ifdef DIV_IQ_FLUSH_EN
  assign flush = b.flush;
`else
  assign flush = 1'b0;
`endif
  // tag 0 is what an idle divider drives onto the CDB, so it never wakes anything
  function automatic logic hit(input logic r, input logic [5:0] t);
    return b.cdb_valid && !r && t == b.cdb_tag && b.cdb_tag != 6'd0;
  endfunction
  assign full = cnt == 4'(DEPTH);
  always_comb begin
    found = 1'b0;
    sel = 0;
    s = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (q[i].v && q[i].r1 && q[i].r2) begin
        found = 1'b1;
        sel = i;
        s = q[i];
      end
    issue = found && !b.unit_busy && !flush;
    accept = b.disp_en && !full;
    for (int i = 0; i < DEPTH; i++) begin
      w[i] = q[i];
      w[i].o1 = q[i].v && hit(q[i].r1, q[i].t1) ? b.cdb_data : q[i].o1;
      w[i].r1 = q[i].r1 || (q[i].v && hit(q[i].r1, q[i].t1));
      w[i].o2 = q[i].v && hit(q[i].r2, q[i].t2) ? b.cdb_data : q[i].o2;
      w[i].r2 = q[i].r2 || (q[i].v && hit(q[i].r2, q[i].t2));
    end
    w[DEPTH] = '0;
    ne.v = 1'b1;
    ne.o1 = hit(b.disp_op1_rdy, b.disp_op1_tag) ? b.cdb_data : b.disp_op1;
    ne.r1 = b.disp_op1_rdy || hit(b.disp_op1_rdy, b.disp_op1_tag);
    ne.t1 = b.disp_op1_tag;
    ne.o2 = hit(b.disp_op2_rdy, b.disp_op2_tag) ? b.cdb_data : b.disp_op2;
    ne.r2 = b.disp_op2_rdy || hit(b.disp_op2_rdy, b.disp_op2_tag);
    ne.t2 = b.disp_op2_tag;
    ne.f3 = b.disp_funct3;
    ne.tag = b.disp_tag;
    cnt_n = cnt - 4'(issue);
    for (int i = 0; i < DEPTH; i++) begin
      n[i] = issue && i >= sel ? w[i+1] : w[i];
      n[i] = accept && i == int'(cnt_n) ? ne : n[i];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '{default: '0};
      cnt <= '0;
    end else if (flush) begin
      q <= '{default: '0};
      cnt <= '0;
    end else begin
      q <= n;
      cnt <= cnt_n + 4'(accept);
    end
  end
  assign b.full     = full;
  assign b.count    = cnt;
  assign b.queue_en = issue;
  assign b.op1      = issue ? s.o1 : '0;
  assign b.op2      = issue ? s.o2 : '0;
  assign b.funct3   = issue ? s.f3 : '0;
  assign b.tag_out  = issue ? s.tag : '0;
endmodule

// File: tb/tb_div_issue_queue.sv
// tb_div_issue_queue: table-driven directed vectors plus reset, tag-0 and flush sequences
module tb_div_issue_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  div_issue_queue_if b();
  div_issue_queue #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .b(b.slave));
  typedef struct {
    logic        en;
    logic [31:0] o1;
    logic        r1;
    logic [5:0]  t1;
    logic [31:0] o2;
    logic        r2;
    logic [5:0]  t2;
    logic [2:0]  f3;
    logic [5:0]  tag;
    logic        cv;
    logic [5:0]  ct;
    logic [31:0] cd;
    logic        busy;
    logic        qen;
    logic [31:0] eo1, eo2;
    logic [2:0]  ef3;
    logic [5:0]  etag;
    logic [3:0]  ecnt;
    logic        efull;
  } vec_t;
  vec_t v[$];
  function automatic vec_t mk(input logic en, input logic [31:0] o1, input logic r1, input logic [5:0] t1,
                              input logic [31:0] o2, input logic r2, input logic [5:0] t2, input logic [2:0] f3,
                              input logic [5:0] tag, input logic cv, input logic [5:0] ct, input logic [31:0] cd,
                              input logic busy, input logic qen, input logic [31:0] eo1, input logic [31:0] eo2,
                              input logic [2:0] ef3, input logic [5:0] etag, input logic [3:0] ecnt, input logic efull);
    vec_t x;
    x.en = en; x.o1 = o1; x.r1 = r1; x.t1 = t1; x.o2 = o2; x.r2 = r2; x.t2 = t2; x.f3 = f3; x.tag = tag;
    x.cv = cv; x.ct = ct; x.cd = cd; x.busy = busy;
    x.qen = qen; x.eo1 = eo1; x.eo2 = eo2; x.ef3 = ef3; x.etag = etag; x.ecnt = ecnt; x.efull = efull;
    return x;
  endfunction
  function automatic vec_t idle(input logic qen, input logic [31:0] eo1, input logic [31:0] eo2,
                                input logic [2:0] ef3, input logic [5:0] etag, input logic [3:0] ecnt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, qen, eo1, eo2, ef3, etag, ecnt, 0);
  endfunction
  task automatic apply(input vec_t x);
    b.disp_en = x.en; b.disp_op1 = x.o1; b.disp_op1_rdy = x.r1; b.disp_op1_tag = x.t1;
    b.disp_op2 = x.o2; b.disp_op2_rdy = x.r2; b.disp_op2_tag = x.t2;
    b.disp_funct3 = x.f3; b.disp_tag = x.tag;
    b.cdb_valid = x.cv; b.cdb_tag = x.ct; b.cdb_data = x.cd; b.unit_busy = x.busy;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    apply(idle(0, 0, 0, 0, 0, 0));
`ifdef DIV_IQ_FLUSH_EN
    b.flush = 1'b0;
`endif
    v.push_back(idle(0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 100, 1, 0, 7, 1, 0, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(idle(1, 100, 7, 4, 5, 1));
    v.push_back(idle(0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 20, 1, 0, 0, 0, 9, 6, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(idle(0, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 3, 0, 0, 0, 0, 0, 0, 1, 0));
    v.push_back(idle(1, 20, 3, 6, 10, 1));
    v.push_back(idle(0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 0, 0, 12, 2, 1, 0, 5, 13, 1, 12, 44, 0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(idle(1, 44, 2, 5, 13, 1));
    v.push_back(idle(0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 0, 0, 20, 1, 1, 0, 1, 21, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 8, 1, 0, 2, 1, 0, 2, 22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    v.push_back(idle(1, 8, 2, 2, 22, 2));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20, 30, 0, 0, 0, 0, 0, 0, 1, 0));
    v.push_back(idle(1, 30, 1, 1, 21, 1));
    v.push_back(idle(0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0, 31, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 2, 1, 0, 0, 0, 40, 3, 32, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 40, 9, 0, 1, 1, 1, 0, 31, 2, 0));
    v.push_back(idle(1, 2, 9, 3, 32, 1));
    v.push_back(idle(0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 3, 1, 0, 4, 1, 0, 7, 33, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 5, 1, 0, 6, 1, 0, 1, 34, 0, 0, 0, 0, 1, 3, 4, 7, 33, 1, 0));
    v.push_back(idle(1, 5, 6, 1, 34, 1));
    v.push_back(idle(0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      v.push_back(mk(1, 32'(k+1), 1, 0, 32'(k+10), 1, 0, 0, 6'(41+k), 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'(k), 0));
    v.push_back(mk(1, 99, 1, 0, 99, 1, 0, 0, 45, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4, 1));
    v.push_back(mk(1, 98, 1, 0, 98, 1, 0, 0, 46, 0, 0, 0, 0, 1, 1, 10, 0, 41, 4, 1));
    for (int k = 1; k < 4; k++)
      v.push_back(idle(1, 32'(k+1), 32'(k+10), 0, 6'(41+k), 4'(4-k)));
    v.push_back(idle(0, 0, 0, 0, 0, 0));
    tick;
    tick;
    rst = 1'b1;
    foreach (v[i]) begin
      apply(v[i]);
      #4;
      chk($sformatf("r%0d_qen", i), 32'(b.queue_en), 32'(v[i].qen));
      chk($sformatf("r%0d_op1", i), b.op1, v[i].eo1);
      chk($sformatf("r%0d_op2", i), b.op2, v[i].eo2);
      chk($sformatf("r%0d_f3", i), 32'(b.funct3), 32'(v[i].ef3));
      chk($sformatf("r%0d_tag", i), 32'(b.tag_out), 32'(v[i].etag));
      chk($sformatf("r%0d_cnt", i), 32'(b.count), 32'(v[i].ecnt));
      chk($sformatf("r%0d_full", i), 32'(b.full), 32'(v[i].efull));
      tick;
    end
    apply(mk(1, 0, 0, 0, 5, 1, 0, 2, 50, 1, 0, 55, 0, 0, 0, 0, 0, 0, 0, 0));
    tick;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 55, 0, 0, 0, 0, 0, 0, 0, 0));
    #4;
    chk("tag0_qen", 32'(b.queue_en), 0);
    chk("tag0_cnt", 32'(b.count), 1);
    tick;
    apply(idle(0, 0, 0, 0, 0, 0));
    #4;
    chk("tag0_hold_qen", 32'(b.queue_en), 0);
    apply(mk(1, 7, 1, 0, 8, 1, 0, 3, 51, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tick;
    apply(idle(0, 0, 0, 0, 0, 0));
    #1;
    chk("pre_rst_cnt", 32'(b.count), 2);
    chk("pre_rst_tag", 32'(b.tag_out), 51);
    rst = 1'b0;
    #1;
    chk("rst_async_cnt", 32'(b.count), 0);
    chk("rst_async_qen", 32'(b.queue_en), 0);
    chk("rst_async_op1", b.op1, 0);
    tick;
    chk("rst_hold_qen", 32'(b.queue_en), 0);
    rst = 1'b1;
    #4;
    chk("rst_rel_cnt", 32'(b.count), 0);
    chk("rst_rel_full", 32'(b.full), 0);
    tick;
`ifdef DIV_IQ_FLUSH_EN
    for (int k = 0; k < 3; k++) begin
      apply(mk(1, 1, 1, 0, 1, 1, 0, 0, 6'(60+k), 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      tick;
    end
    apply(idle(0, 0, 0, 0, 0, 0));
    #4;
    chk("fl_pre_cnt", 32'(b.count), 3);
    chk("fl_pre_qen", 32'(b.queue_en), 1);
    apply(mk(1, 9, 1, 0, 9, 1, 0, 0, 63, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    b.flush = 1'b1;
    #1;
    chk("fl_qen_comb", 32'(b.queue_en), 0);
    tick;
    b.flush = 1'b0;
    apply(idle(0, 0, 0, 0, 0, 0));
    #4;
    chk("fl_cnt", 32'(b.count), 0);
    chk("fl_full", 32'(b.full), 0);
    chk("fl_qen", 32'(b.queue_en), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
